// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter: sizes, sense constants
// and the arbiter state encoding.
package dma_pkg;

    localparam int unsigned DMA_NCH  = 4;
    localparam int unsigned DMA_CH_W = 2;

    localparam logic DREQ_ACT_HIGH = 1'b0;
    localparam logic DREQ_ACT_LOW  = 1'b1;
    localparam logic DACK_ACT_LOW  = 1'b0;
    localparam logic DACK_ACT_HIGH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2,
        REL  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_priority_encoder.sv
// Picks one requesting channel: lowest index in fixed mode, or the first
// requester after the last-served channel (wrapping) in rotating mode.
import dma_pkg::*;

module dma_priority_encoder #(
    parameter int unsigned NCH  = DMA_NCH,
    parameter int unsigned CH_W = DMA_CH_W
) (
    input  logic [NCH-1:0]  eff,
    input  logic [CH_W-1:0] last,
    input  logic            rotating,
    output logic [CH_W-1:0] winner,
    output logic            any_req
);

    logic [CH_W-1:0] sel;

    // Scan from lowest to highest priority so the highest-priority hit lands last.
    always_comb begin
        winner  = '0;
        sel     = '0;
        any_req = |eff;
        for (int unsigned k = NCH; k >= 1; k--) begin
            sel = rotating ? CH_W'((32'(last) + k) % NCH) : CH_W'(k - 1);
            if (eff[sel]) begin
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: merges DREQ/software requests, arbitrates, and runs
// the HRQ/HLDA hold handshake before acknowledging the granted channel.
import dma_pkg::*;

module dma_priority_arbiter #(
    parameter int unsigned NCH  = DMA_NCH,
    parameter int unsigned CH_W = DMA_CH_W
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [NCH-1:0]  DREQ,
    input  logic            DREQ_Sense,
    input  logic            DACK_Sense,
    input  logic [NCH-1:0]  SoftReq,
    input  logic [NCH-1:0]  Mask,
    input  logic            Rotating,
    input  logic            Disable,
    input  logic            HLDA,
    input  logic            Xfer_Done,
    input  logic            EOP,
    output logic            HRQ,
    output logic [NCH-1:0]  DACK,
    output logic [CH_W-1:0] Channel,
    output logic            Grant_Valid,
    output logic [NCH-1:0]  Clear_SoftReq
);

    dma_state_e      state;
    logic [NCH-1:0]  eff;
    logic [NCH-1:0]  dack_act;
    logic [CH_W-1:0] last;
    logic [CH_W-1:0] winner;
    logic            any_req;
    logic            done;

    // Software requests bypass the mask; hardware lines are normalised to active-high first.
    assign eff  = ((DREQ ^ {NCH{DREQ_Sense}}) & ~Mask) | SoftReq;
    assign done = Xfer_Done | EOP;

    dma_priority_encoder #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_prio (
        .eff      (eff),
        .last     (last),
        .rotating (Rotating),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            HRQ           <= 1'b0;
            Grant_Valid   <= 1'b0;
            Channel       <= '0;
            Clear_SoftReq <= '0;
            dack_act      <= '0;
            last          <= CH_W'(NCH - 1);
        end else begin
            Clear_SoftReq <= '0;
            case (state)
                IDLE: begin
                    if (!Disable && any_req) begin
                        Channel <= winner;
                        HRQ     <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (HLDA) begin
                        Grant_Valid <= 1'b1;
                        dack_act    <= NCH'(1) << Channel;
                        state       <= SVC;
                    end
                end
                SVC: begin
                    if (done) begin
                        HRQ           <= 1'b0;
                        Grant_Valid   <= 1'b0;
                        dack_act      <= '0;
                        Clear_SoftReq <= SoftReq[Channel] ? NCH'(1) << Channel : '0;
                        if (Rotating) begin
                            last <= Channel;
                        end
                        state <= REL;
                    end
                end
                REL: begin
                    if (!HLDA) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the acknowledge polarity follows DACK_Sense without a register stage.
    assign DACK = (DACK_Sense == DACK_ACT_HIGH) ? dack_act : ~dack_act;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed-vector bench for dma_priority_arbiter with hand-computed expectations.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] DREQ;
    logic       DREQ_Sense;
    logic       DACK_Sense;
    logic [3:0] SoftReq;
    logic [3:0] Mask;
    logic       Rotating;
    logic       Disable;
    logic       HLDA;
    logic       Xfer_Done;
    logic       EOP;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] Channel;
    logic       Grant_Valid;
    logic [3:0] Clear_SoftReq;

    int nvec = 0;
    int nmis = 0;

    dma_priority_arbiter dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .DREQ          (DREQ),
        .DREQ_Sense    (DREQ_Sense),
        .DACK_Sense    (DACK_Sense),
        .SoftReq       (SoftReq),
        .Mask          (Mask),
        .Rotating      (Rotating),
        .Disable       (Disable),
        .HLDA          (HLDA),
        .Xfer_Done     (Xfer_Done),
        .EOP           (EOP),
        .HRQ           (HRQ),
        .DACK          (DACK),
        .Channel       (Channel),
        .Grant_Valid   (Grant_Valid),
        .Clear_SoftReq (Clear_SoftReq)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        Reset     = 1'b1;
        HLDA      = 1'b0;
        Xfer_Done = 1'b0;
        EOP       = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    // One full grant: wait HRQ, return HLDA after 2 cycles, complete, drop HLDA.
    task automatic grant(input string tag, input logic [1:0] exp_ch, input logic [3:0] exp_dack,
                         input logic [3:0] idle_dack, input logic [3:0] exp_clr,
                         input bit use_eop, input bit dis_in_svc);
        int waited = 0;
        while (!HRQ && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check_val({tag, " hrq_rise"}, 32'(HRQ), 32'd1);
        check_val({tag, " channel"}, 32'(Channel), 32'(exp_ch));
        repeat (2) @(negedge CLK);
        HLDA = 1'b1;
        @(negedge CLK);
        check_val({tag, " grant_valid"}, 32'(Grant_Valid), 32'd1);
        check_val({tag, " dack"}, 32'(DACK), 32'(exp_dack));
        if (dis_in_svc) Disable = 1'b1;
        if (use_eop) EOP = 1'b1; else Xfer_Done = 1'b1;
        @(negedge CLK);
        EOP       = 1'b0;
        Xfer_Done = 1'b0;
        check_val({tag, " hrq_fall"}, 32'(HRQ), 32'd0);
        check_val({tag, " gv_fall"}, 32'(Grant_Valid), 32'd0);
        check_val({tag, " dack_rel"}, 32'(DACK), 32'(idle_dack));
        check_val({tag, " clr_pulse"}, 32'(Clear_SoftReq), 32'(exp_clr));
        HLDA = 1'b0;
        @(negedge CLK);
        check_val({tag, " clr_end"}, 32'(Clear_SoftReq), 32'd0);
    endtask

    initial begin
        logic seen;
        DREQ = 4'b0000; DREQ_Sense = 1'b0; DACK_Sense = 1'b0;
        SoftReq = 4'b0000; Mask = 4'b0000; Rotating = 1'b0; Disable = 1'b0;
        reset_dut();

        check_val("rst hrq", 32'(HRQ), 32'd0);
        check_val("rst gv", 32'(Grant_Valid), 32'd0);
        check_val("rst channel", 32'(Channel), 32'd0);
        check_val("rst clr", 32'(Clear_SoftReq), 32'd0);
        check_val("rst dack", 32'(DACK), 32'hF);

        // Fixed priority: ch1 beats ch2, and wins again on the next round.
        DREQ = 4'b0110;
        grant("fix1", 2'd1, 4'b1101, 4'hF, 4'h0, 1'b0, 1'b0);
        grant("fix2", 2'd1, 4'b1101, 4'hF, 4'h0, 1'b0, 1'b0);

        // Rotating priority walks 0,1,2,3 and wraps to 0.
        DREQ = 4'b0000; Rotating = 1'b1;
        reset_dut();
        DREQ = 4'b1111;
        grant("rot0", 2'd0, 4'b1110, 4'hF, 4'h0, 1'b0, 1'b0);
        grant("rot1", 2'd1, 4'b1101, 4'hF, 4'h0, 1'b0, 1'b0);
        grant("rot2", 2'd2, 4'b1011, 4'hF, 4'h0, 1'b0, 1'b0);
        grant("rot3", 2'd3, 4'b0111, 4'hF, 4'h0, 1'b0, 1'b0);
        grant("rotw", 2'd0, 4'b1110, 4'hF, 4'h0, 1'b0, 1'b0);

        // Masked hardware requests, unmaskable software request on ch2.
        Rotating = 1'b0; DREQ = 4'b0000;
        reset_dut();
        Mask = 4'b1111; DREQ = 4'b1111; SoftReq = 4'b0100;
        grant("soft", 2'd2, 4'b1011, 4'hF, 4'b0100, 1'b0, 1'b0);
        SoftReq = 4'b0000;
        @(negedge CLK);
        check_val("soft idle", 32'(HRQ), 32'd0);

        // Disable blocks new grants but not one already in service.
        Mask = 4'b0000; DREQ = 4'b0001; Disable = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            seen = seen | HRQ;
        end
        check_val("dis hold", 32'(seen), 32'd0);
        Disable = 1'b0;
        grant("dis svc", 2'd0, 4'b1110, 4'hF, 4'h0, 1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        check_val("dis after", 32'(HRQ), 32'd0);
        Disable = 1'b0;

        // Asynchronous reset while in SVC.
        reset_dut();
        DREQ = 4'b0001;
        @(negedge CLK);
        @(negedge CLK);
        HLDA = 1'b1;
        @(negedge CLK);
        check_val("arst pre gv", 32'(Grant_Valid), 32'd1);
        #1 Reset = 1'b1;
        #1;
        check_val("arst hrq", 32'(HRQ), 32'd0);
        check_val("arst dack", 32'(DACK), 32'hF);
        check_val("arst gv", 32'(Grant_Valid), 32'd0);
        check_val("arst clr", 32'(Clear_SoftReq), 32'd0);
        DREQ = 4'b0000;
        reset_dut();

        // EOP completes a transfer the same way as Xfer_Done.
        DREQ = 4'b1000;
        grant("eop", 2'd3, 4'b0111, 4'hF, 4'h0, 1'b1, 1'b0);

        // Inverted sense on both request and acknowledge.
        DREQ = 4'b1111;
        DREQ_Sense = 1'b1; DACK_Sense = 1'b1;
        reset_dut();
        check_val("sense rst dack", 32'(DACK), 32'h0);
        DREQ = 4'b1110;
        grant("sense", 2'd0, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
